// File: rtl/lsu_bus_master.sv
// Load/store bus master: checks and steers one CPU access onto a word-wide data bus,
// waits for grant and response (with a timeout), and returns extended load data.
module lsu_bus_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] rs2_data,
    output logic        lsu_done,
    output logic [31:0] load_data,
    output logic        lsu_err,
    output logic [1:0]  err_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    // Counter value at which one more cycle without progress times out.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 2);

    state_t      state_q, state_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] load_data_q, load_data_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        illegal, misaligned, tmo;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, sh, ext;

    always_comb begin
        illegal = (mem_re == mem_we) ||
                  (mem_re ? (funct3 inside {3'b011, 3'b110, 3'b111}) : (funct3 > 3'b010));
        unique case (funct3[1:0])
            2'b00: begin
                misaligned = 1'b0;
                be_new     = 4'b0001 << addr[1:0];
                wdata_new  = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                misaligned = addr[0];
                be_new     = 4'b0011 << addr[1:0];
                wdata_new  = {2{rs2_data[15:0]}};
            end
            default: begin
                misaligned = (addr[1:0] != 2'b00);
                be_new     = 4'b1111;
                wdata_new  = rs2_data;
            end
        endcase
    end

    always_comb begin
        sh = bus_rdata >> {off_q, 3'b000};
        unique case (funct3_q)
            3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
            3'b100:  ext = {24'h0, sh[7:0]};
            3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
            3'b101:  ext = {16'h0, sh[15:0]};
            default: ext = bus_rdata;
        endcase
    end

    assign tmo = (cnt_q >= TMO_LAST);

    always_comb begin
        state_d     = state_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        cause_d     = cause_q;
        load_data_d = load_data_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            S_IDLE: if (lsu_valid) begin
                funct3_d = funct3;
                off_d    = addr[1:0];
                if (illegal || misaligned) begin
                    // Rejected accesses never touch the bus.
                    cause_d     = illegal ? 2'b11 : 2'b01;
                    load_data_d = 32'h0;
                    state_d     = S_RESP;
                end else begin
                    cause_d     = 2'b00;
                    bus_we_d    = mem_we;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = be_new;
                    bus_wdata_d = wdata_new;
                    cnt_d       = 8'h0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_gnt) begin
                    state_d = S_WAIT;
                end else if (tmo) begin
                    cause_d     = 2'b10;
                    load_data_d = 32'h0;
                    state_d     = S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_rvalid) begin
                    cause_d     = bus_err ? 2'b10 : 2'b00;
                    load_data_d = (bus_err || bus_we_q) ? 32'h0 : ext;
                    state_d     = S_RESP;
                end else if (tmo) begin
                    cause_d     = 2'b10;
                    load_data_d = 32'h0;
                    state_d     = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            funct3_q    <= 3'h0;
            off_q       <= 2'h0;
            cause_q     <= 2'h0;
            load_data_q <= 32'h0;
            cnt_q       <= 8'h0;
        end else begin
            state_q     <= state_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            cause_q     <= cause_d;
            load_data_q <= load_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign lsu_ready = (state_q == S_IDLE);
    assign bus_req   = (state_q == S_REQ);
    assign lsu_done  = (state_q == S_RESP);
    assign lsu_err   = lsu_done && (cause_q != 2'b00);
    assign err_cause = lsu_done ? cause_q : 2'b00;
    assign load_data = load_data_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: directed vector table, timeout cases on a short-timeout
// instance, a mid-transaction reset, and randomized accesses against a byte-level model.
module tb_lsu_bus_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, lsu_valid = 1'b0, lsu_valid4 = 1'b0;
    logic        mem_re = 1'b0, mem_we = 1'b0;
    logic [2:0]  funct3 = 3'h0;
    logic [31:0] addr = 32'h0, rs2_data = 32'h0, bus_rdata = 32'h0;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
    logic        sel4 = 1'b0;

    logic        m_ready, m_done, m_err, m_breq, m_bwe, t_ready, t_done, t_err, t_breq, t_bwe;
    logic [1:0]  m_cause, t_cause;
    logic [3:0]  m_bbe, t_bbe;
    logic [31:0] m_ld, m_baddr, m_bwdata, t_ld, t_baddr, t_bwdata;

    lsu_bus_master #(.TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .lsu_ready(m_ready),
        .mem_re(mem_re), .mem_we(mem_we), .funct3(funct3), .addr(addr), .rs2_data(rs2_data),
        .lsu_done(m_done), .load_data(m_ld), .lsu_err(m_err), .err_cause(m_cause),
        .bus_req(m_breq), .bus_we(m_bwe), .bus_addr(m_baddr), .bus_be(m_bbe), .bus_wdata(m_bwdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err));

    lsu_bus_master #(.TIMEOUT(4)) u_dut4 (
        .clk(clk), .rst(rst), .lsu_valid(lsu_valid4), .lsu_ready(t_ready),
        .mem_re(mem_re), .mem_we(mem_we), .funct3(funct3), .addr(addr), .rs2_data(rs2_data),
        .lsu_done(t_done), .load_data(t_ld), .lsu_err(t_err), .err_cause(t_cause),
        .bus_req(t_breq), .bus_we(t_bwe), .bus_addr(t_baddr), .bus_be(t_bbe), .bus_wdata(t_bwdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err));

    logic        ready, done, err, breq, bwe;
    logic [1:0]  cause;
    logic [3:0]  bbe;
    logic [31:0] ld, baddr, bwdata;
    assign ready  = sel4 ? t_ready  : m_ready;
    assign done   = sel4 ? t_done   : m_done;
    assign err    = sel4 ? t_err    : m_err;
    assign breq   = sel4 ? t_breq   : m_breq;
    assign bwe    = sel4 ? t_bwe    : m_bwe;
    assign cause  = sel4 ? t_cause  : m_cause;
    assign bbe    = sel4 ? t_bbe    : m_bbe;
    assign ld     = sel4 ? t_ld     : m_ld;
    assign baddr  = sel4 ? t_baddr  : m_baddr;
    assign bwdata = sel4 ? t_bwdata : m_bwdata;

    typedef struct {
        logic re, we; logic [2:0] f3; logic [31:0] a, rs2;
        int gd, rd; logic [31:0] rdata; logic berr;
    } req_t;
    typedef struct {
        int lat, reqc; logic [3:0] be; logic [31:0] baddr, wdata, ld;
        logic we, err; logic [1:0] cause;
    } exp_t;
    typedef struct { req_t r; exp_t e; } vec_t;

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Expected result computed byte by byte from the access rules.
    function automatic exp_t model(input req_t r);
        exp_t e;
        int nb, off;
        logic [31:0] v;
        e = '{0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0};
        nb  = 1 << r.f3[1:0];
        off = int'(r.a[1:0]);
        if (r.re == r.we) e.cause = 2'd3;
        else if (r.re ? !(r.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : !(r.f3 inside {3'd0, 3'd1, 3'd2}))
            e.cause = 2'd3;
        else if (off % nb != 0) e.cause = 2'd1;
        if (e.cause != 2'd0) begin
            e.lat = 1; e.err = 1'b1;
            return e;
        end
        e.lat = 3 + r.gd + r.rd;
        e.reqc = r.gd + 1;
        e.baddr = r.a & ~32'h3;
        e.we = r.we;
        for (int k = 0; k < 4; k++) begin
            e.be[k] = (k >= off) && (k < off + nb);
            e.wdata[8*k +: 8] = r.rs2[8*(k % nb) +: 8];
        end
        if (r.berr) begin
            e.err = 1'b1; e.cause = 2'd2;
        end else if (r.re) begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = r.rdata[8*(off+i) +: 8];
            if (!r.f3[2] && nb < 4 && v[8*nb-1])
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            e.ld = v;
        end
        return e;
    endfunction

    // Issues one access at a negedge with the DUT idle, plays the bus side, and checks.
    task automatic do_txn(input req_t r, input exp_t e, input bit use4, input bit noise, input string tag);
        int cyc, reqc, wc;
        bit granted, stable, quiet;
        logic [3:0] be0;
        logic [31:0] a0, w0;
        logic we0;
        sel4 = use4;
        #0;
        chk({tag, ".ready"}, 32'(ready), 32'd1);
        mem_re = r.re; mem_we = r.we; funct3 = r.f3; addr = r.a; rs2_data = r.rs2;
        if (use4) lsu_valid4 = 1'b1; else lsu_valid = 1'b1;
        @(negedge clk);
        lsu_valid = 1'b0; lsu_valid4 = 1'b0;
        cyc = 1; reqc = 0; wc = 0; granted = 0; stable = 1; quiet = 1;
        be0 = 4'h0; a0 = 32'h0; w0 = 32'h0; we0 = 1'b0;
        while (done !== 1'b1 && cyc < 64) begin
            if (err !== 1'b0 || cause !== 2'd0 || ready !== 1'b0) quiet = 0;
            if (breq === 1'b1) begin
                if (reqc == 0) begin
                    be0 = bbe; a0 = baddr; w0 = bwdata; we0 = bwe;
                end else if ({bbe, baddr, bwdata, bwe} !== {be0, a0, w0, we0}) stable = 0;
                bus_gnt = (reqc == r.gd);
                if (noise) begin bus_rvalid = 1'($urandom); bus_err = 1'b1; end
                if (bus_gnt) granted = 1;
                reqc++;
            end else if (granted) begin
                bus_rvalid = (wc == r.rd);
                bus_err = bus_rvalid & r.berr;
                bus_rdata = bus_rvalid ? r.rdata : $urandom;
                wc++;
            end
            if (noise && !use4) begin
                lsu_valid = 1'($urandom); mem_re = 1'($urandom); mem_we = 1'($urandom);
                funct3 = 3'($urandom); addr = $urandom; rs2_data = $urandom;
            end
            @(negedge clk);
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; lsu_valid = 1'b0;
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'(e.lat));
        chk({tag, ".req_cycles"}, 32'(reqc), 32'(e.reqc));
        if (e.reqc > 0) begin
            chk({tag, ".bus_be"}, 32'(be0), 32'(e.be));
            chk({tag, ".bus_addr"}, a0, e.baddr);
            chk({tag, ".bus_we"}, 32'(we0), 32'(e.we));
            if (e.we) chk({tag, ".bus_wdata"}, w0, e.wdata);
            chk({tag, ".req_stable"}, 32'(stable), 32'd1);
        end
        chk({tag, ".lsu_err"}, 32'(err), 32'(e.err));
        chk({tag, ".err_cause"}, 32'(cause), 32'(e.cause));
        chk({tag, ".load_data"}, ld, e.ld);
        chk({tag, ".quiet_busy"}, 32'(quiet), 32'd1);
        @(negedge clk);
        chk({tag, ".after_resp"}, 32'({done, ready, err, cause}), 32'b01000);
        chk({tag, ".ld_hold"}, ld, e.ld);
        sel4 = 1'b0;
    endtask

    vec_t tbl[13];
    req_t rr;
    exp_t ee;
    logic [2:0] lf3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        //          re we f3    addr         rs2            gd rd rdata          berr   lat rq be       baddr   wdata          ld             we err cause
        tbl[0]  = '{'{1, 0, 3'd0, 32'h6, 32'h0, 0, 0, 32'h12F03456, 0}, '{3, 1, 4'b0100, 32'h4, 32'h0, 32'hFFFFFFF0, 0, 0, 2'd0}};
        tbl[1]  = '{'{1, 0, 3'd4, 32'h6, 32'h0, 0, 0, 32'h12F03456, 0}, '{3, 1, 4'b0100, 32'h4, 32'h0, 32'h000000F0, 0, 0, 2'd0}};
        tbl[2]  = '{'{0, 1, 3'd1, 32'hA, 32'hDEADBEEF, 3, 1, 32'h0, 0}, '{7, 4, 4'b1100, 32'h8, 32'hBEEFBEEF, 32'h0, 1, 0, 2'd0}};
        tbl[3]  = '{'{1, 0, 3'd2, 32'h2, 32'h0, 0, 0, 32'h0, 0}, '{1, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 1, 2'd1}};
        tbl[4]  = '{'{1, 0, 3'd3, 32'h0, 32'h0, 0, 0, 32'h0, 0}, '{1, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 1, 2'd3}};
        tbl[5]  = '{'{1, 1, 3'd2, 32'h0, 32'h0, 0, 0, 32'h0, 0}, '{1, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 1, 2'd3}};
        tbl[6]  = '{'{1, 0, 3'd2, 32'h10, 32'h0, 0, 0, 32'hAAAA5555, 1}, '{3, 1, 4'hF, 32'h10, 32'h0, 32'h0, 0, 1, 2'd2}};
        tbl[7]  = '{'{1, 0, 3'd5, 32'h2, 32'h0, 1, 2, 32'h80011234, 0}, '{6, 2, 4'b1100, 32'h0, 32'h0, 32'h00008001, 0, 0, 2'd0}};
        tbl[8]  = '{'{1, 0, 3'd1, 32'h2, 32'h0, 1, 2, 32'h80011234, 0}, '{6, 2, 4'b1100, 32'h0, 32'h0, 32'hFFFF8001, 0, 0, 2'd0}};
        tbl[9]  = '{'{0, 1, 3'd2, 32'hC, 32'h01234567, 0, 0, 32'h0, 0}, '{3, 1, 4'hF, 32'hC, 32'h01234567, 32'h0, 1, 0, 2'd0}};
        tbl[10] = '{'{0, 1, 3'd0, 32'h3, 32'h000000AB, 0, 0, 32'h0, 0}, '{3, 1, 4'b1000, 32'h0, 32'hABABABAB, 32'h0, 1, 0, 2'd0}};
        tbl[11] = '{'{0, 1, 3'd4, 32'h0, 32'h0, 0, 0, 32'h0, 0}, '{1, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 1, 2'd3}};
        tbl[12] = '{'{0, 1, 3'd1, 32'h1, 32'h0, 0, 0, 32'h0, 0}, '{1, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 1, 2'd1}};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel4 = 1'(s);
            #0;
            chk($sformatf("reset%0d.ctrl", s), 32'({ready, done, err, cause, breq, bwe, bbe}), 32'b1000_0000_000);
            chk($sformatf("reset%0d.data", s), baddr | bwdata | ld, 32'h0);
        end
        sel4 = 1'b0;

        foreach (tbl[i]) do_txn(tbl[i].r, tbl[i].e, 1'b0, 1'b0, $sformatf("vec%0d", i));

        // Short-timeout instance: no grant, late grant, no response.
        rr = '{1, 0, 3'd2, 32'h20, 32'h0, -1, 0, 32'h0, 0};
        do_txn(rr, '{4, 3, 4'hF, 32'h20, 32'h0, 32'h0, 0, 1, 2'd2}, 1'b1, 1'b0, "tmo_req");
        rr = '{1, 0, 3'd2, 32'h24, 32'h0, 2, 0, 32'h13579BDF, 0};
        do_txn(rr, '{5, 3, 4'hF, 32'h24, 32'h0, 32'h13579BDF, 0, 0, 2'd0}, 1'b1, 1'b0, "tmo_gnt_wins");
        rr = '{1, 0, 3'd2, 32'h28, 32'h0, 0, -1, 32'h0, 0};
        do_txn(rr, '{4, 1, 4'hF, 32'h28, 32'h0, 32'h0, 0, 1, 2'd2}, 1'b1, 1'b0, "tmo_wait");

        // Reset while waiting for the response; the late rvalid must be ignored.
        mem_re = 1'b1; mem_we = 1'b0; funct3 = 3'd2; addr = 32'h40; lsu_valid = 1'b1;
        @(negedge clk); lsu_valid = 1'b0; bus_gnt = 1'b1;
        @(negedge clk); bus_gnt = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        chk("rst_mid.ctrl", 32'({ready, done, err, cause, breq, bwe, bbe}), 32'b1000_0000_000);
        chk("rst_mid.data", baddr | bwdata | ld, 32'h0);
        @(negedge clk); bus_rvalid = 1'b0;
        chk("rst_mid.late_rvalid", 32'({ready, done, err}), 32'b100);
        chk("rst_mid.ld", ld, 32'h0);

        for (int n = 0; n < 250; n++) begin
            rr.re = 1'($urandom);
            rr.we = !rr.re;
            if ($urandom % 10 == 0) rr.we = rr.re;
            if ($urandom % 6 == 0) rr.f3 = 3'($urandom);
            else rr.f3 = rr.re ? lf3[$urandom % 5] : lf3[$urandom % 3];
            rr.a = $urandom;
            if ($urandom % 2 == 0) rr.a[1:0] = 2'b00;
            rr.rs2 = $urandom;
            rr.gd = int'($urandom % 4);
            rr.rd = int'($urandom % 4);
            rr.rdata = $urandom;
            rr.berr = ($urandom % 8 == 0);
            ee = model(rr);
            do_txn(rr, ee, 1'b0, 1'b1, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_bus_master.md
# lsu_bus_master

Load/store unit that drives the data-memory bus from the CPU side. It accepts one load or store per transaction and uses RISC-V funct3 encoding. It checks legality and alignment, generates a word-aligned bus request with byte enables and lane-replicated write data, then waits for the grant and response. For loads it extracts and sign/zero-extends the addressed bytes. It sits between the execute stage and the data memory, and it stalls the core through `lsu_ready`/`lsu_done`.

## Interface
- `TIMEOUT`, 255: cycles allowed in REQ+WAIT before a bus timeout error; legal range 2..255.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `lsu_valid` in 1: CPU request strobe; accepted when `lsu_ready`=1.
- `lsu_ready` out 1: FSM in IDLE.
- `mem_re` in 1: load request.
- `mem_we` in 1: store request.
- `funct3` in 3: access size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000/001/010).
- `addr` in 32: byte address.
- `rs2_data` in 32: store data.
- `lsu_done` out 1: one-cycle completion pulse.
- `load_data` out 32: extended load result, valid with `lsu_done`.
- `lsu_err` out 1: transaction failed, valid with `lsu_done`.
- `err_cause` out 2: 01 misaligned, 10 bus error/timeout, 11 illegal op.
- `bus_req` out 1: bus request.
- `bus_we` out 1: write request.
- `bus_addr` out 32: `{addr[31:2],2'b00}`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_gnt` in 1: request accepted.
- `bus_rvalid` in 1: response (read data or write ack).
- `bus_rdata` in 32: read data.
- `bus_err` in 1: response error, qualified by `bus_rvalid`.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- **IDLE** (`lsu_ready`=1). On `lsu_valid`, latch the request and check it in this priority order:
  - `mem_re`==`mem_we` → cause 11.
  - Illegal funct3 (load 011/110/111; store other than 000/001/010) → cause 11.
  - Misaligned (half with `addr[0]`=1, word with `addr[1:0]`≠0) → cause 01.
  - Any error → RESP with no bus activity. Otherwise → REQ and clear the timeout counter.
- **REQ**: `bus_req`=1. `bus_we`, `bus_addr`, `bus_be`, `bus_wdata` come from latched registers and stay stable until grant. On `bus_gnt` → WAIT.
- **WAIT**: `bus_req`=0. On `bus_rvalid`, capture the result and → RESP.
  - `bus_err`=1 → cause 10, `load_data`=0.
  - Otherwise, for a load, `load_data` = the extracted value.
- **RESP**: `lsu_done`=1 for exactly one cycle → IDLE.
- Byte lanes, with off=`addr[1:0]`:
  - Byte: be=`4'b0001<<off`, wdata=`{4{rs2[7:0]}}`.
  - Half: be=`4'b0011<<off`, wdata=`{2{rs2[15:0]}}`.
  - Word: be=`4'b1111`, wdata=`rs2`.
  - Loads use the same be.
- Load extract: sh=`bus_rdata>>(8*off)`.
  - LB sign-extends `sh[7:0]`; LBU zero-extends it.
  - LH sign-extends `sh[15:0]`; LHU zero-extends it.
  - LW returns `bus_rdata`.
- `load_data` is 0 for stores and errors. It holds its value between RESP pulses.
- Timeout: the counter increments each cycle in REQ or WAIT. If it reaches TIMEOUT-1 with no `bus_gnt` (REQ) or no `bus_rvalid` (WAIT), → RESP with cause 10.
  - On a timeout in REQ, `bus_req` drops at the next edge.
  - A `bus_gnt` or `bus_rvalid` arriving in the same cycle as the timeout wins; no error is raised.

## Timing
- Reset (synchronous, sampled on the clk edge):
  - State=IDLE.
  - `bus_req`=0, `bus_we`=0, `bus_be`=0, `bus_addr`=0, `bus_wdata`=0.
  - `lsu_done`=0, `lsu_err`=0, `err_cause`=0, `load_data`=0, counter=0.
  - `lsu_ready`=1 from the first cycle after reset.
- Reset mid-transaction aborts to IDLE. A late `bus_gnt`/`bus_rvalid` arriving in IDLE is ignored.
- Minimum latency (accept in cycle t, `bus_gnt` in t+1, `bus_rvalid` in t+2): `lsu_done` in t+3.
- Error path (accepted in t): `lsu_done` in t+1.
- `bus_rvalid` is ignored outside WAIT, including in the same cycle as `bus_gnt`.
- `lsu_valid` is ignored while `lsu_ready`=0. The next request may be accepted in the cycle after RESP.
- `lsu_err` and `err_cause` are valid only with `lsu_done`. Both read 0 in all other cycles.

## Test plan
- **LB**, addr=0x0000_0006, gnt in t+1, rvalid t+2 with rdata=0x12F0_3456:
  - bus: `bus_addr`=0x4, `bus_be`=0100.
  - `lsu_done` at t+3, `load_data`=0xFFFF_FFF0.
  - LBU on the same access: `load_data`=0x0000_00F0.
- **SH**, addr=0x0000_000A, rs2=0xDEAD_BEEF, gnt delayed 3 cycles:
  - `bus_req` held 4 cycles with `bus_we`=1, `bus_be`=1100, `bus_wdata`=0xBEEF_BEEF, `bus_addr`=0x8 stable.
  - `lsu_done` pulses after rvalid with `lsu_err`=0.
- **Misalignment and illegal ops**:
  - LW at 0x2 → `lsu_done` at t+1 with cause 01 and no `bus_req`.
  - funct3=011 load → cause 11.
  - `mem_re`=`mem_we`=1 → cause 11.
- **Bus error**: LW at 0x10, rvalid with `bus_err`=1 → `lsu_err`=1, cause 10, `load_data`=0.
- **Timeout**, TIMEOUT=4, `bus_gnt` never asserted → `bus_req` high 3 cycles, then `lsu_done` with cause 10.
  - Repeat with `bus_gnt` arriving in the 3rd REQ cycle → proceeds normally with no error.
- **Reset mid-transaction**: `rst` during WAIT, then `bus_rvalid`=1 the next cycle → no `lsu_done`, `lsu_ready`=1, all bus outputs 0.
